// File: rtl/muxn_stream_pkg.sv
// Shared constants for the muxn_stream channel selector and its arbiter.
// Holds the MODE encodings and a constant clog2 used for parameter checks.
package muxn_stream_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muxn_stream_rr_arbiter.sv
// Combinational rotate-priority encoder: searches req from ptr+1 upward,
// wrapping modulo NCH, and returns the first requesting channel.
module muxn_stream_rr_arbiter
  import muxn_stream_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            enable,
  output logic            grant_valid,
  output logic [SELW-1:0] grant
);

  generate
    if (SELW < clog2(NCH)) begin : g_bad_selw
      $error("muxn_stream_rr_arbiter: SELW too narrow for NCH");
    end
  endgenerate

  int c;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    c           = 0;
    for (int k = 1; k <= NCH; k++) begin
      c = (int'(ptr) + k) % NCH;
      if (enable && !grant_valid && req[c]) begin
        grant_valid = 1'b1;
        grant       = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// NCH-channel stream selector with a registered output stage, selecting
// either by external sel (MODE=0) or by round-robin over valid channels.
//
// Handshake: a beat moves on a rising clk edge exactly when valid and ready
// are both high on that side; valid never waits on ready, while din_ready is
// allowed to depend combinationally on dout_ready, sel and din_valid.
module muxn_stream
  import muxn_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = MUX_MODE_SEL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH-1:0]       din_valid,
  output logic [NCH-1:0]       din_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [SELW-1:0]      dout_ch
);

  generate
    if (SELW < clog2(NCH) || NCH < 2 || NCH > 16) begin : g_bad_param
      $error("muxn_stream: NCH must be 2..16 and SELW >= clog2(NCH)");
    end
    if (MODE != MUX_MODE_SEL && MODE != MUX_MODE_RR) begin : g_bad_mode
      $error("muxn_stream: unknown MODE");
    end
  endgenerate

  logic            load;
  logic            xfer;
  logic            sel_valid;
  logic            rr_valid;
  logic            grant_valid;
  logic [SELW-1:0] rr_grant;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] ptr;
  logic [WIDTH-1:0] din_sel;

  muxn_stream_rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req         (din_valid),
    .ptr         (ptr),
    .enable      (MODE == MUX_MODE_RR),
    .grant_valid (rr_valid),
    .grant       (rr_grant)
  );

  // Out-of-range sel values match no channel, so they never grant.
  always_comb begin
    sel_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i) && din_valid[i]) sel_valid = 1'b1;
    end
  end

  assign grant       = (MODE == MUX_MODE_RR) ? rr_grant : sel;
  assign grant_valid = (MODE == MUX_MODE_RR) ? rr_valid : sel_valid;
  assign load        = !dout_valid || dout_ready;

  always_comb begin
    din_ready = '0;
    din_sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        din_ready[i] = !reset && load && grant_valid;
        din_sel      = din[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |din_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      ptr        <= SELW'(NCH - 1);
    end else if (xfer) begin
      dout       <= din_sel;
      dout_ch    <= grant;
      dout_valid <= 1'b1;
      if (MODE == MUX_MODE_RR) ptr <= grant;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
